wb_unit: RTL

Writeback unit for the nano_rv32i core: the write-side master of the register file. It merges single-cycle ALU results with load results from the load/store unit into the register file's single write port (`reg_write`/`rd`/`write_data`). ALU results always have priority; load results are held in a 2-entry FIFO and drained in order on cycles without an ALU result. A per-register pending mask is exported for the hazard unit.

---
 rtl/wb_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_unit.sv
// -----------------------------------------------------------------------------
// wb_unit -- writeback unit for the nano_rv32i core
//
// Purpose:
//   Sole write-side master of the register file. Each cycle it picks at most
//   one result for the single register-file write port:
//     1. an ALU result (it cannot be stalled, so it always wins),
//     2. otherwise the oldest buffered load result (FIFO head),
//     3. otherwise a load accepted this very cycle, which bypasses the FIFO.
//   Load results that are accepted but lose arbitration are held in a
//   2-entry FIFO and drained in acceptance order. A per-register pending
//   mask of the buffered loads is exported for the hazard unit.
//
// Optional feature:
//   WB_LOAD_EXT_EN -- when defined, raw load words are byte/half extracted
//   and sign/zero extended (LB/LH/LBU/LHU) before being written or stored.
//   When undefined, lsu_data_i is passed through untouched and
//   lsu_funct3_i / lsu_addr_lo_i are ignored.
//
// Parameters:
//   DEPTH            load FIFO depth (only 2 is supported)
//
// Ports:
//   clk_i            clock, rising edge
//   rst_n_i          asynchronous active-low reset
//   alu_valid_i      ALU result valid this cycle
//   alu_rd_i         ALU destination register
//   alu_data_i       ALU result
//   lsu_valid_i      load result offered
//   lsu_ready_o      a load result can be accepted (count < 2)
//   lsu_rd_i         load destination register
//   lsu_data_i       raw aligned memory word
//   lsu_funct3_i     RV32I load funct3
//   lsu_addr_lo_i    byte address bits [1:0]
//   reg_write_o      register file write enable (registered)
//   rd_o             register file destination (registered)
//   write_data_o     register file write data (registered)
//   lsu_pend_mask_o  bit n set while a load to xn is held in the FIFO
//   fifo_count_o     FIFO occupancy 0..2
// -----------------------------------------------------------------------------
module wb_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [1:0]  lsu_addr_lo_i,
    output logic        reg_write_o,
    output logic [4:0]  rd_o,
    output logic [31:0] write_data_o,
    output logic [31:0] lsu_pend_mask_o,
    output logic [1:0]  fifo_count_o
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

`ifdef WB_LOAD_EXT_EN
    // Extract the addressed byte/half from the aligned word and extend it.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  addr_lo
    );
        logic signed [7:0]  byte_val;
        logic signed [15:0] half_val;
        logic [31:0]        res;
        case (addr_lo)
            2'd0:    byte_val = word[7:0];
            2'd1:    byte_val = word[15:8];
            2'd2:    byte_val = word[23:16];
            default: byte_val = word[31:24];
        endcase
        half_val = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  res = {{24{byte_val[7]}}, byte_val};   // LB
            3'b001:  res = {{16{half_val[15]}}, half_val};  // LH
            3'b100:  res = {24'd0, byte_val};                // LBU
            3'b101:  res = {16'd0, half_val};                // LHU
            default: res = word;                             // LW and reserved
        endcase
        return res;
    endfunction
`endif

    // FIFO control state
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic [1:0]  ent_vld;

    // FIFO payload (captured on push, never reset)
    logic [4:0]  ent_rd   [2];
    logic [31:0] ent_data [2];

    // Registered write port and pending mask
    logic        reg_write_p1;
    logic [4:0]  rd_p1;
    logic [31:0] wdata_p1;
    logic [31:0] pend_mask_p1;

    // Combinational next-state signals
    logic        ready;
    logic        accept;
    logic        pop;
    logic        bypass;
    logic        push;
    logic [31:0] load_data;
    logic        sel_vld_p0;
    logic [4:0]  sel_rd_p0;
    logic [31:0] sel_data_p0;
    logic [1:0]  count_n;
    logic [1:0]  ent_vld_n;
    logic [4:0]  ent_rd_n [2];
    logic [31:0] pend_mask_n;

`ifdef WB_LOAD_EXT_EN
    assign load_data = load_extend(lsu_data_i, lsu_funct3_i, lsu_addr_lo_i);
`else
    logic unused_load_ctrl;
    assign unused_load_ctrl = ^{lsu_funct3_i, lsu_addr_lo_i};
    assign load_data        = lsu_data_i;
`endif

    // ---- stage 0: arbitration and FIFO next state ----
    assign ready  = (count < FULL_COUNT);
    assign accept = lsu_valid_i && ready;
    assign pop    = !alu_valid_i && (count != 2'd0);
    assign bypass = !alu_valid_i && (count == 2'd0) && accept;
    assign push   = accept && !bypass;

    always_comb begin
        sel_vld_p0  = 1'b0;
        sel_rd_p0   = 5'd0;
        sel_data_p0 = 32'd0;
        if (alu_valid_i) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = alu_rd_i;
            sel_data_p0 = alu_data_i;
        end else if (pop) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = ent_rd[head];
            sel_data_p0 = ent_data[head];
        end else if (bypass) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = lsu_rd_i;
            sel_data_p0 = load_data;
        end
    end

    // At count 1 a push and a pop touch different slots, so the order of the
    // two updates below does not matter.
    always_comb begin
        ent_vld_n   = ent_vld;
        ent_rd_n[0] = ent_rd[0];
        ent_rd_n[1] = ent_rd[1];
        if (pop) begin
            ent_vld_n[head] = 1'b0;
        end
        if (push) begin
            ent_vld_n[tail] = 1'b1;
            ent_rd_n[tail]  = lsu_rd_i;
        end
    end

    // Duplicate rd values simply OR together, so a bit stays set as long as
    // any valid entry still targets that register.
    always_comb begin
        pend_mask_n = 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (ent_vld_n[i] && (ent_rd_n[i] != 5'd0)) begin
                pend_mask_n[ent_rd_n[i]] = 1'b1;
            end
        end
    end

    assign count_n = count + {1'b0, push} - {1'b0, pop};

    // ---- stage 1: registered control, write port and mask ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count        <= 2'd0;
            head         <= 1'b0;
            tail         <= 1'b0;
            ent_vld      <= 2'b00;
            pend_mask_p1 <= 32'd0;
            reg_write_p1 <= 1'b0;
            rd_p1        <= 5'd0;
            wdata_p1     <= 32'd0;
        end else begin
            count        <= count_n;
            ent_vld      <= ent_vld_n;
            pend_mask_p1 <= pend_mask_n;
            if (pop) begin
                head <= ~head;
            end
            if (push) begin
                tail <= ~tail;
            end
            // x0 targets are consumed and shown on rd/data but never written.
            reg_write_p1 <= sel_vld_p0 && (sel_rd_p0 != 5'd0);
            if (sel_vld_p0) begin
                rd_p1    <= sel_rd_p0;
                wdata_p1 <= sel_data_p0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_rd[tail]   <= lsu_rd_i;
            ent_data[tail] <= load_data;
        end
    end

    assign lsu_ready_o     = ready;
    assign reg_write_o     = reg_write_p1;
    assign rd_o            = rd_p1;
    assign write_data_o    = wdata_p1;
    assign lsu_pend_mask_o = pend_mask_p1;
    assign fifo_count_o    = count;

endmodule
